commit_arf: RTL and testbench

Retirement-side stage fed directly by the reorder buffer's commit output. Holds the 32-entry architectural register file (ARF) and the rename-alias table (RAT). It accepts in-order commits over a valid/ready handshake, writes committed results to the ARF, and retires RAT mappings. On a committing exception or branch mispredict it clears all speculative RAT state, raises a one-cycle flush, and issues a fetch redirect. Dispatch uses its source-lookup and rename ports.

---
 rtl/commit_arf.sv | 166 ++++++++++++++++
 tb/tb_commit_arf.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_arf.sv
// Retirement stage: architectural register file plus rename-alias table, fed by the ROB commit port.
// Commits write the ARF and retire RAT mappings. Exceptions and mispredicts flush the RAT and redirect fetch.
module commit_arf #(
    parameter int                DATA_W       = 32,
    parameter int                TAG_W        = 4,
    parameter logic [DATA_W-1:0] HANDLER_PC   = 'h80,
    parameter int                FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rename_en,
    input  logic [4:0]        rename_rd,
    input  logic [TAG_W-1:0]  rename_tag,
    output logic              rename_ready,
    input  logic [4:0]        src1_reg,
    input  logic [4:0]        src2_reg,
    output logic              src1_ready,
    output logic              src2_ready,
    output logic [DATA_W-1:0] src1_val,
    output logic [DATA_W-1:0] src2_val,
    output logic [TAG_W-1:0]  src1_tag,
    output logic [TAG_W-1:0]  src2_tag,
    input  logic              commit_valid,
    output logic              commit_ready,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic              commit_wen,
    input  logic [4:0]        commit_dest,
    input  logic [DATA_W-1:0] commit_value,
    input  logic              commit_except,
    input  logic              commit_mispredict,
    input  logic [DATA_W-1:0] commit_target,
    output logic              flush,
    output logic [DATA_W-1:0] redirect_pc,
    output logic [31:0]       retired_count,
    output logic [15:0]       except_count
);
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic {RUN = 1'b0, FLUSHING = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  arf [32];
    logic [31:0]        rat_vld;
    logic [TAG_W-1:0]   rat_tag [32];
    logic               commit_fire, rename_fire, flush_trig, arf_wr, bypass_ok;
    logic [4:0]         src_reg [2];
    logic [1:0]         src_rdy;
    logic [DATA_W-1:0]  src_v [2];
    logic [TAG_W-1:0]   src_t [2];

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign commit_fire = commit_valid && commit_ready;
    assign rename_fire = rename_en && rename_ready;
    assign flush_trig  = commit_fire && (commit_except || commit_mispredict);
    assign arf_wr      = commit_fire && !commit_except && commit_wen && (commit_dest != 5'd0);
    // A faulting entry never produces a usable result, so it is never bypassed.
    assign bypass_ok   = commit_fire && commit_wen && !commit_except;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (flush_trig)
                cnt_q <= CNT_LOAD;
            else if (state_q == FLUSHING && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (flush_trig) state_d = FLUSHING;
            FLUSHING: if (cnt_q == '0) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        commit_ready = 1'b0;
        rename_ready = 1'b0;
        if (!rst && state_q == RUN) begin
            commit_ready = 1'b1;
            rename_ready = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) arf[i] <= '0;
        end else if (arf_wr) begin
            arf[commit_dest] <= commit_value;
        end
    end

    // Later assignments win: a same-cycle rename overrides the commit's retirement of that entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rat_vld <= '0;
        end else if (flush_trig) begin
            rat_vld <= '0;
        end else begin
            if (commit_fire && rat_vld[commit_dest] && rat_tag[commit_dest] == commit_tag)
                rat_vld[commit_dest] <= 1'b0;
            if (rename_fire && rename_rd != 5'd0)
                rat_vld[rename_rd] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rename_fire && !flush_trig && rename_rd != 5'd0)
            rat_tag[rename_rd] <= rename_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush         <= 1'b0;
            redirect_pc   <= '0;
            retired_count <= '0;
            except_count  <= '0;
        end else begin
            flush <= flush_trig;
            if (flush_trig)
                redirect_pc <= commit_except ? HANDLER_PC : commit_target;
            if (commit_fire && !commit_except)
                retired_count <= retired_count + 32'd1;
            if (commit_fire && commit_except)
                except_count <= sat_inc16(except_count);
        end
    end

    assign src_reg[0] = src1_reg;
    assign src_reg[1] = src2_reg;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            src_rdy[p] = 1'b1;
            src_v[p]   = '0;
            src_t[p]   = '0;
            if (src_reg[p] != 5'd0) begin
                src_t[p] = rat_tag[src_reg[p]];
                if (!rat_vld[src_reg[p]])
                    src_v[p] = arf[src_reg[p]];
                else if (bypass_ok && rat_tag[src_reg[p]] == commit_tag)
                    src_v[p] = commit_value;
                else
                    src_rdy[p] = 1'b0;
            end
        end
    end

    assign src1_ready = src_rdy[0];
    assign src2_ready = src_rdy[1];
    assign src1_val   = src_v[0];
    assign src2_val   = src_v[1];
    assign src1_tag   = src_t[0];
    assign src2_tag   = src_t[1];

endmodule

// File: tb/tb_commit_arf.sv
// Directed bench for commit_arf: table of single-cycle vectors plus hand-written flush and reset sequences.
module tb_commit_arf;
    logic        clk = 1'b0;
    logic        rst;
    logic        rename_en;
    logic [4:0]  rename_rd;
    logic [3:0]  rename_tag;
    logic        rename_ready;
    logic [4:0]  src1_reg, src2_reg;
    logic        src1_ready, src2_ready;
    logic [31:0] src1_val, src2_val;
    logic [3:0]  src1_tag, src2_tag;
    logic        commit_valid, commit_ready;
    logic [3:0]  commit_tag;
    logic        commit_wen;
    logic [4:0]  commit_dest;
    logic [31:0] commit_value;
    logic        commit_except, commit_mispredict;
    logic [31:0] commit_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] retired_count;
    logic [15:0] except_count;

    int total = 0;
    int bad   = 0;

    commit_arf #(.DATA_W(32), .TAG_W(4), .HANDLER_PC(32'h80), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .rename_en(rename_en), .rename_rd(rename_rd), .rename_tag(rename_tag), .rename_ready(rename_ready),
        .src1_reg(src1_reg), .src2_reg(src2_reg),
        .src1_ready(src1_ready), .src2_ready(src2_ready),
        .src1_val(src1_val), .src2_val(src2_val),
        .src1_tag(src1_tag), .src2_tag(src2_tag),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_tag(commit_tag),
        .commit_wen(commit_wen), .commit_dest(commit_dest), .commit_value(commit_value),
        .commit_except(commit_except), .commit_mispredict(commit_mispredict), .commit_target(commit_target),
        .flush(flush), .redirect_pc(redirect_pc),
        .retired_count(retired_count), .except_count(except_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ren;
        logic [4:0]  rrd;
        logic [3:0]  rtag;
        logic        cv;
        logic [3:0]  ctag;
        logic        cwen;
        logic [4:0]  cdest;
        logic [31:0] cval;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic        e1r;
        logic [31:0] e1v;
        logic [3:0]  e1t;
        logic        e2r;
        logic [31:0] e2v;
        logic [3:0]  e2t;
        logic [31:0] eret;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rename_en = 1'b0; rename_rd = '0; rename_tag = '0;
        commit_valid = 1'b0; commit_tag = '0; commit_wen = 1'b0; commit_dest = '0;
        commit_value = '0; commit_except = 1'b0; commit_mispredict = 1'b0; commit_target = '0;
    endtask

    task automatic chk_src(input string nm, input logic [4:0] r, input logic rdy, input logic [31:0] v);
        src1_reg = r;
        #1;
        chk({nm, "_rdy"}, 32'(src1_ready), 32'(rdy));
        chk({nm, "_val"}, src1_val, v);
    endtask

    initial begin
        // rename r5->3, then commit it with bypass, then read it back
        tbl[0]  = '{1, 5, 3,  0, 0, 0, 0, 0,          5, 0,  1, 0, 0,        1, 0, 0,         0};
        tbl[1]  = '{0, 0, 0,  0, 0, 0, 0, 0,          5, 6,  0, 0, 3,        1, 0, 0,         0};
        tbl[2]  = '{0, 0, 0,  1, 3, 1, 5, 32'hDEAD,   5, 5,  1, 32'hDEAD, 0, 1, 32'hDEAD, 0, 0};
        tbl[3]  = '{0, 0, 0,  0, 0, 0, 0, 0,          5, 0,  1, 32'hDEAD, 0, 1, 0, 0,         1};
        // stale commit: r7 renamed twice, older tag commits
        tbl[4]  = '{1, 7, 2,  0, 0, 0, 0, 0,          7, 0,  1, 0, 0,        1, 0, 0,         1};
        tbl[5]  = '{1, 7, 9,  0, 0, 0, 0, 0,          7, 0,  0, 0, 2,        1, 0, 0,         1};
        tbl[6]  = '{0, 0, 0,  1, 2, 1, 7, 32'h11,     7, 0,  0, 0, 9,        1, 0, 0,         1};
        tbl[7]  = '{0, 0, 0,  0, 0, 0, 0, 0,          7, 5,  0, 0, 9,        1, 32'hDEAD, 0,  2};
        // r0 write and rename are ignored
        tbl[8]  = '{1, 0, 5,  1, 1, 1, 0, 32'h77,     0, 0,  1, 0, 0,        1, 0, 0,         2};
        tbl[9]  = '{0, 0, 0,  0, 0, 0, 0, 0,          0, 0,  1, 0, 0,        1, 0, 0,         3};
        // same-cycle rename and commit of r8: new tag kept, ARF written
        tbl[10] = '{1, 8, 4,  0, 0, 0, 0, 0,          8, 0,  1, 0, 0,        1, 0, 0,         3};
        tbl[11] = '{1, 8, 10, 1, 4, 1, 8, 32'h88,     8, 0,  1, 32'h88, 0,   1, 0, 0,         3};
        tbl[12] = '{0, 0, 0,  0, 0, 0, 0, 0,          8, 9,  0, 0, 10,       1, 0, 0,         4};
        // commit without a register write
        tbl[13] = '{0, 0, 0,  1, 11, 0, 9, 32'h99,    9, 0,  1, 0, 0,        1, 0, 0,         4};
        tbl[14] = '{0, 0, 0,  0, 0, 0, 0, 0,          9, 0,  1, 0, 0,        1, 0, 0,         5};

        // ---- reset ----
        idle();
        rst = 1'b1; src1_reg = 5'd5; src2_reg = 5'd0;
        #2;
        chk("rst_commit_ready", 32'(commit_ready), 0);
        chk("rst_rename_ready", 32'(rename_ready), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_redirect", redirect_pc, 0);
        chk("rst_retired", retired_count, 0);
        chk("rst_except", 32'(except_count), 0);
        chk("rst_s1_rdy", 32'(src1_ready), 1);
        chk("rst_s1_val", src1_val, 0);
        chk("rst_s2_rdy", 32'(src2_ready), 1);
        cyc(); cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rel_commit_ready", 32'(commit_ready), 1);
        chk("rel_rename_ready", 32'(rename_ready), 1);
        cyc();

        // ---- table vectors ----
        for (int i = 0; i < 15; i++) begin
            rename_en = tbl[i].ren; rename_rd = tbl[i].rrd; rename_tag = tbl[i].rtag;
            commit_valid = tbl[i].cv; commit_tag = tbl[i].ctag; commit_wen = tbl[i].cwen;
            commit_dest = tbl[i].cdest; commit_value = tbl[i].cval;
            commit_except = 1'b0; commit_mispredict = 1'b0; commit_target = '0;
            src1_reg = tbl[i].s1; src2_reg = tbl[i].s2;
            #2;
            chk($sformatf("v%0d_s1_rdy", i), 32'(src1_ready), 32'(tbl[i].e1r));
            chk($sformatf("v%0d_s1_val", i), src1_val, tbl[i].e1v);
            if (!tbl[i].e1r) chk($sformatf("v%0d_s1_tag", i), 32'(src1_tag), 32'(tbl[i].e1t));
            chk($sformatf("v%0d_s2_rdy", i), 32'(src2_ready), 32'(tbl[i].e2r));
            chk($sformatf("v%0d_s2_val", i), src2_val, tbl[i].e2v);
            if (!tbl[i].e2r) chk($sformatf("v%0d_s2_tag", i), 32'(src2_tag), 32'(tbl[i].e2t));
            chk($sformatf("v%0d_retired", i), retired_count, tbl[i].eret);
            chk($sformatf("v%0d_commit_ready", i), 32'(commit_ready), 1);
            chk($sformatf("v%0d_flush", i), 32'(flush), 0);
            cyc();
        end
        idle();

        // ---- exception commit ----
        rename_en = 1'b1; rename_rd = 5'd4; rename_tag = 4'd6;
        cyc();
        idle();
        commit_valid = 1'b1; commit_tag = 4'd6; commit_wen = 1'b1; commit_dest = 5'd4;
        commit_value = 32'h55; commit_except = 1'b1;
        cyc();
        // blocked cycles: offered commit and rename must be ignored
        idle();
        commit_valid = 1'b1; commit_tag = 4'd12; commit_wen = 1'b1; commit_dest = 5'd10; commit_value = 32'hAA;
        rename_en = 1'b1; rename_rd = 5'd11; rename_tag = 4'd1;
        #1;
        chk("exc_flush", 32'(flush), 1);
        chk("exc_redirect", redirect_pc, 32'h80);
        chk("exc_count", 32'(except_count), 1);
        chk("exc_retired", retired_count, 5);
        chk("exc_commit_ready1", 32'(commit_ready), 0);
        chk("exc_rename_ready1", 32'(rename_ready), 0);
        cyc();
        chk("exc_flush_drop", 32'(flush), 0);
        chk("exc_redirect_hold", redirect_pc, 32'h80);
        chk("exc_commit_ready2", 32'(commit_ready), 0);
        chk("exc_rename_ready2", 32'(rename_ready), 0);
        cyc();
        idle();
        chk("exc_commit_ready3", 32'(commit_ready), 1);
        chk("exc_rename_ready3", 32'(rename_ready), 1);
        chk("exc_retired_after", retired_count, 5);
        chk_src("exc_r4", 5'd4, 1'b1, 32'h0);
        chk_src("exc_r7", 5'd7, 1'b1, 32'h11);
        chk_src("exc_r8", 5'd8, 1'b1, 32'h88);
        chk_src("exc_r10", 5'd10, 1'b1, 32'h0);
        chk_src("exc_r11", 5'd11, 1'b1, 32'h0);
        cyc();

        // ---- mispredict with link write and discarded rename ----
        commit_valid = 1'b1; commit_tag = 4'd0; commit_wen = 1'b1; commit_dest = 5'd1;
        commit_value = 32'h40; commit_mispredict = 1'b1; commit_target = 32'h200;
        rename_en = 1'b1; rename_rd = 5'd2; rename_tag = 4'd14;
        cyc();
        idle();
        src2_reg = 5'd2;
        #1;
        chk("mis_flush", 32'(flush), 1);
        chk("mis_redirect", redirect_pc, 32'h200);
        chk("mis_retired", retired_count, 6);
        chk("mis_except", 32'(except_count), 1);
        chk("mis_r2_rdy", 32'(src2_ready), 1);
        chk_src("mis_r1", 5'd1, 1'b1, 32'h40);
        cyc();
        chk("mis_flush_drop", 32'(flush), 0);
        chk("mis_redirect_hold", redirect_pc, 32'h200);
        chk("mis_ready2", 32'(commit_ready), 0);
        cyc();
        chk("mis_ready3", 32'(commit_ready), 1);
        chk("mis_rename_ready3", 32'(rename_ready), 1);

        // ---- reset in the middle of a flush ----
        commit_valid = 1'b1; commit_tag = 4'd3; commit_except = 1'b1;
        cyc();
        idle();
        chk("mid_flush", 32'(flush), 1);
        chk("mid_except", 32'(except_count), 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_flush", 32'(flush), 0);
        chk("mid_rst_ready", 32'(commit_ready), 0);
        chk("mid_rst_except", 32'(except_count), 0);
        chk("mid_rst_redirect", redirect_pc, 0);
        chk_src("mid_rst_r1", 5'd1, 1'b1, 32'h0);
        cyc();
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", 32'(commit_ready), 1);
        chk("mid_rel_rename_ready", 32'(rename_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
